// File: rtl/gpio_serial_xfer.sv
// Serial configuration loader for the user-project GPIO pad control chains.
// Streams one CTRL_BITS word per pad into NUM_CHAINS parallel chains, then strobes the load.

module gpio_serial_lane #(
  parameter int PADS = 19,
  parameter int CB   = 13,
  parameter int KW   = 5,
  parameter bit DIR  = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [PADS*CB-1:0] i_words,
  input  logic [KW-1:0]      i_pad,
  input  logic               i_load,
  input  logic               i_shift,
  output logic               o_msb
);
  logic [CB-1:0] r_stage;
  logic [CB-1:0] w_word;
  int            w_idx;

  // Ascending chains start at pad 0, descending chains at the far end.
  always_comb begin
    w_idx  = DIR ? int'(i_pad) : PADS - 1 - int'(i_pad);
    w_word = i_words[w_idx*CB +: CB];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_stage <= '0;
    else if (i_load)  r_stage <= w_word;
    else if (i_shift) r_stage <= {r_stage[CB-2:0], 1'b0};
  end

  assign o_msb = r_stage[CB-1];
endmodule

module gpio_serial_xfer #(
  parameter int                    NUM_CHAINS     = 2,
  parameter int                    PADS_PER_CHAIN = 19,
  parameter int                    CTRL_BITS      = 13,
  parameter int                    CLK_DIV        = 1,
  parameter logic [NUM_CHAINS-1:0] CHAIN_DIR      = '0
) (
  input  logic                                           wb_clk_i,
  input  logic                                           wb_rst_i,
  input  logic [NUM_CHAINS*PADS_PER_CHAIN*CTRL_BITS-1:0] cfg_data,
  input  logic                                           start,
  input  logic                                           abort,
  output logic                                           busy,
  output logic                                           done,
  output logic                                           serial_clock,
  output logic                                           serial_resetn,
  output logic [NUM_CHAINS-1:0]                          serial_data_out
);
  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(CTRL_BITS);
  localparam int KW = (PADS_PER_CHAIN > 1) ? $clog2(PADS_PER_CHAIN) : 1;
  localparam int CW = PADS_PER_CHAIN * CTRL_BITS;

  localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(CTRL_BITS - 1);
  localparam logic [KW-1:0] PAD_LAST = KW'(PADS_PER_CHAIN - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;

  state_t          r_state, w_state_nxt;
  logic [PW-1:0]   r_phase, w_phase_nxt;
  logic            r_half,  w_half_nxt;
  logic [BW-1:0]   r_bit,   w_bit_nxt;
  logic [KW-1:0]   r_pad,   w_pad_nxt;
  logic            r_done,  w_done_nxt;
  logic            r_rel;
  logic            w_load, w_shift, w_half_end;
  logic [NUM_CHAINS-1:0] w_msb;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_phase <= '0;
      r_half  <= 1'b0;
      r_bit   <= '0;
      r_pad   <= '0;
      r_done  <= 1'b0;
      r_rel   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_half  <= w_half_nxt;
      r_bit   <= w_bit_nxt;
      r_pad   <= w_pad_nxt;
      r_done  <= w_done_nxt;
      r_rel   <= 1'b1;
    end
  end

  // r_half selects the low (0) or high (1) half of a serial_clock period or latch pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_half_nxt  = r_half;
    w_bit_nxt   = r_bit;
    w_pad_nxt   = r_pad;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    w_half_end  = (r_phase == PH_LAST);
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_LOAD;
          w_pad_nxt   = '0;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = S_SHIFT;
        w_bit_nxt   = '0;
        w_phase_nxt = '0;
        w_half_nxt  = 1'b0;
      end
      S_SHIFT: begin
        if (!w_half_end) begin
          w_phase_nxt = r_phase + 1'b1;
        end else begin
          w_phase_nxt = '0;
          w_half_nxt  = ~r_half;
          if (r_half) begin
            w_shift = 1'b1;
            if (r_bit != BIT_LAST) begin
              w_bit_nxt = r_bit + 1'b1;
            end else if (r_pad == PAD_LAST) begin
              w_state_nxt = S_LATCH;
            end else begin
              w_pad_nxt   = r_pad + 1'b1;
              w_state_nxt = S_LOAD;
            end
          end
        end
      end
      S_LATCH: begin
        if (!w_half_end) begin
          w_phase_nxt = r_phase + 1'b1;
        end else begin
          w_phase_nxt = '0;
          w_half_nxt  = ~r_half;
          if (r_half) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (abort && r_state != S_IDLE) begin
      w_state_nxt = S_IDLE;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_done_nxt  = 1'b0;
    end
  end

  for (genvar c = 0; c < NUM_CHAINS; c++) begin : g_lane
    gpio_serial_lane #(
      .PADS (PADS_PER_CHAIN),
      .CB   (CTRL_BITS),
      .KW   (KW),
      .DIR  (CHAIN_DIR[c])
    ) u_lane (
      .i_clk   (wb_clk_i),
      .i_rst   (wb_rst_i),
      .i_words (cfg_data[c*CW +: CW]),
      .i_pad   (r_pad),
      .i_load  (w_load),
      .i_shift (w_shift),
      .o_msb   (w_msb[c])
    );
  end

  // r_rel keeps the chains in reset until the first edge after wb_rst_i drops.
  assign busy            = (r_state != S_IDLE);
  assign done            = r_done;
  assign serial_clock    = (r_state == S_SHIFT) && r_half;
  assign serial_resetn   = r_rel && !((r_state == S_LATCH) && !r_half);
  assign serial_data_out = (r_state == S_SHIFT) ? w_msb : '0;
endmodule

// File: tb/tb_gpio_serial_xfer.sv
// Bench for gpio_serial_xfer: three configurations checked against a bit-order model.
module tb_gpio_serial_xfer;
  logic clk = 1'b0;
  logic rst;
  logic mclr;
  logic [2:0] st;
  logic ab;
  logic [493:0] cfg0, cfg1;
  logic [159:0] cfg2;
  logic [2:0] bsy, dn, sc, rn;
  logic [1:0] sdo0, sdo1;
  logic [3:0] sdo2;
  logic [3:0] sdo [3];
  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign sdo[0] = {2'b00, sdo0};
  assign sdo[1] = {2'b00, sdo1};
  assign sdo[2] = sdo2;

  gpio_serial_xfer u0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_data(cfg0), .start(st[0]), .abort(ab),
    .busy(bsy[0]), .done(dn[0]), .serial_clock(sc[0]), .serial_resetn(rn[0]),
    .serial_data_out(sdo0));

  gpio_serial_xfer #(.CLK_DIV(3), .CHAIN_DIR(2'b10)) u1 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_data(cfg1), .start(st[1]), .abort(ab),
    .busy(bsy[1]), .done(dn[1]), .serial_clock(sc[1]), .serial_resetn(rn[1]),
    .serial_data_out(sdo1));

  gpio_serial_xfer #(.NUM_CHAINS(4), .PADS_PER_CHAIN(5), .CTRL_BITS(8)) u2 (
    .wb_clk_i(clk), .wb_rst_i(rst), .cfg_data(cfg2), .start(st[2]), .abort(ab),
    .busy(bsy[2]), .done(dn[2]), .serial_clock(sc[2]), .serial_resetn(rn[2]),
    .serial_data_out(sdo2));

  // Monitor: counts busy/done/latch-low cycles, captures data at each serial_clock rise.
  int   bcnt [3], dcnt [3], rlow [3], run [3];
  int   hmin [3], hmax [3], lmin [3], lmax [3];
  int   ncap [3][4];
  logic cap  [3][4][512];
  logic hi   [3][4];
  logic [2:0] psc;

  always @(negedge clk) begin
    if (mclr) begin
      for (int d = 0; d < 3; d++) begin
        bcnt[d] <= 0; dcnt[d] <= 0; rlow[d] <= 0; run[d] <= 0;
        hmin[d] <= 9999; hmax[d] <= 0; lmin[d] <= 9999; lmax[d] <= 0;
        psc[d] <= 1'b0;
        for (int c = 0; c < 4; c++) begin
          ncap[d][c] <= 0;
          hi[d][c]   <= 1'b0;
        end
      end
    end else begin
      for (int d = 0; d < 3; d++) begin
        if (bsy[d]) bcnt[d] <= bcnt[d] + 1;
        if (dn[d]) dcnt[d] <= dcnt[d] + 1;
        if (!rst && !rn[d]) rlow[d] <= rlow[d] + 1;
        for (int c = 0; c < 4; c++) begin
          if (sdo[d][c]) hi[d][c] <= 1'b1;
          if (sc[d] && !psc[d] && ncap[d][c] < 512) begin
            cap[d][c][ncap[d][c]] <= sdo[d][c];
            ncap[d][c] <= ncap[d][c] + 1;
          end
        end
        if (!bsy[d]) run[d] <= 0;
        else if (sc[d] == psc[d]) run[d] <= run[d] + 1;
        else begin
          run[d] <= 1;
          if (psc[d]) begin
            if (run[d] < hmin[d]) hmin[d] <= run[d];
            if (run[d] > hmax[d]) hmax[d] <= run[d];
          end else begin
            if (run[d] < lmin[d]) lmin[d] <= run[d];
            if (run[d] > lmax[d]) lmax[d] <= run[d];
          end
        end
        psc[d] <= sc[d];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Bit j seen on chain c: pad word in shift order, MSB first, repeating per transfer.
  function automatic logic exp_bit(int d, int c, int j);
    int p, cb, m, b, pad;
    logic dir;
    p   = (d == 2) ? 5 : 19;
    cb  = (d == 2) ? 8 : 13;
    dir = (d == 1 && c == 1);
    m   = (j % (p * cb)) / cb;
    b   = cb - 1 - (j % cb);
    pad = dir ? m : p - 1 - m;
    case (d)
      0:       return cfg0[(c*p + pad)*cb + b];
      1:       return cfg1[(c*p + pad)*cb + b];
      default: return cfg2[(c*p + pad)*cb + b];
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    tick(1); mclr = 1'b1;
    tick(1); mclr = 1'b0;
  endtask

  task automatic pulse_start(input int d);
    tick(1); st[d] = 1'b1;
    tick(1); st[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int n, input int budget);
    int k;
    k = 0;
    while (dcnt[d] < n && k < budget) begin
      tick(1);
      k++;
    end
    tick(3);
  endtask

  task automatic check_xfer(input int d, input int n, input int t, input int dv,
                            input int nch, input int p, input int cb);
    int bad;
    chk($sformatf("busy_cycles d%0d", d), bcnt[d], n * t);
    chk($sformatf("done_pulses d%0d", d), dcnt[d], n);
    chk($sformatf("latch_low d%0d", d), rlow[d], n * dv);
    for (int c = 0; c < nch; c++) begin
      chk($sformatf("bit_count d%0d c%0d", d, c), ncap[d][c], n * p * cb);
      bad = 0;
      for (int j = 0; j < ncap[d][c]; j++)
        if (cap[d][c][j] !== exp_bit(d, c, j)) bad++;
      chk($sformatf("bit_data d%0d c%0d", d, c), bad, 0);
    end
  endtask

  initial begin
    int k;
    rst = 1'b0; mclr = 1'b1; st = '0; ab = 1'b0;
    cfg0 = '0; cfg1 = '0; cfg2 = '0;
    #1 rst = 1'b1;
    #2;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("rst_busy d%0d", d), bsy[d], 0);
      chk($sformatf("rst_done d%0d", d), dn[d], 0);
      chk($sformatf("rst_sclk d%0d", d), sc[d], 0);
      chk($sformatf("rst_resetn d%0d", d), rn[d], 0);
      chk($sformatf("rst_sdo d%0d", d), sdo[d], 0);
    end
    tick(1); rst = 1'b0;
    tick(1);
    for (int d = 0; d < 3; d++) chk($sformatf("release_resetn d%0d", d), rn[d], 1);
    mclr = 1'b0;

    // Defaults with indexed pad words; re-pulsed start ignored, restart in done cycle.
    for (int i = 0; i < 38; i++) cfg0[i*13 +: 13] = 13'((i * 'h101) & 'h1FFF);
    clear_mon();
    pulse_start(0);
    tick(9);  st[0] = 1'b1; tick(1); st[0] = 1'b0;
    tick(189); st[0] = 1'b1; tick(1); st[0] = 1'b0;
    k = 0;
    while (dn[0] !== 1'b1 && k < 2000) begin
      tick(1);
      k++;
    end
    chk("done_seen", dn[0], 1);
    st[0] = 1'b1; tick(1); st[0] = 1'b0;
    chk("restart_busy", bsy[0], 1);
    wait_done(0, 2, 2000);
    check_xfer(0, 2, 515, 1, 2, 19, 13);

    // Divided clock, chain 1 ascending, random words.
    for (int i = 0; i < 494; i++) cfg1[i] = 1'($urandom);
    clear_mon();
    pulse_start(1);
    wait_done(1, 1, 4000);
    check_xfer(1, 1, 1507, 3, 2, 19, 13);
    chk("sclk_high_min", hmin[1], 3);
    chk("sclk_high_max", hmax[1], 3);
    chk("sclk_low_min", lmin[1], 3);
    chk("sclk_low_max", lmax[1], 4);

    // Four short chains, only chain 2 all ones.
    for (int i = 0; i < 5; i++) cfg2[(10 + i)*8 +: 8] = 8'hFF;
    clear_mon();
    pulse_start(2);
    wait_done(2, 1, 500);
    check_xfer(2, 1, 87, 1, 4, 5, 8);
    chk("ones_c0", hi[2][0], 0);
    chk("ones_c1", hi[2][1], 0);
    chk("ones_c2", hi[2][2], 1);
    chk("ones_c3", hi[2][3], 0);
    for (int i = 0; i < 160; i++) cfg2[i] = 1'($urandom);
    clear_mon();
    pulse_start(2);
    wait_done(2, 1, 500);
    check_xfer(2, 1, 87, 1, 4, 5, 8);

    // Abort mid-transfer.
    clear_mon();
    pulse_start(0);
    tick(99);
    ab = 1'b1; tick(1); ab = 1'b0;
    chk("abort_busy", bsy[0], 0);
    chk("abort_sclk", sc[0], 0);
    chk("abort_sdo", sdo[0], 0);
    chk("abort_resetn", rn[0], 1);
    tick(600);
    chk("abort_no_done", dcnt[0], 0);
    chk("abort_no_latch", rlow[0], 0);
    chk("abort_idle", bsy[0], 0);

    // Reset mid-transfer, then a fresh transfer.
    clear_mon();
    pulse_start(0);
    tick(299);
    rst = 1'b1;
    #1;
    chk("midrst_resetn", rn[0], 0);
    chk("midrst_busy", bsy[0], 0);
    chk("midrst_sclk", sc[0], 0);
    chk("midrst_sdo", sdo[0], 0);
    tick(2); rst = 1'b0;
    tick(1);
    chk("midrst_release", rn[0], 1);
    clear_mon();
    pulse_start(0);
    wait_done(0, 1, 2000);
    check_xfer(0, 1, 515, 1, 2, 19, 13);

    $display("CHECKS %0d ERRORS %0d", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/gpio_serial_xfer.md
# gpio_serial_xfer

Parametrised serial configuration loader for the user-project GPIO control chains. It replaces the fixed two-chain, 13-bit, full-speed shifter inside the project control block. It streams a per-pad control word from a flat configuration vector into NUM_CHAINS daisy-chained pad control blocks, all in parallel, then pulses the shared load strobe. Additions over the previous generation: a programmable serial clock divider, a per-chain shift direction, an abort input, and a completion pulse.

## Interface
- NUM_CHAINS, 2, number of independent serial chains (≥1)
- PADS_PER_CHAIN, 19, pads clocked per chain; all chains share one clock and are equal length
- CTRL_BITS, 13, control bits per pad word (2..32)
- CLK_DIV, 1, wb_clk_i cycles per serial_clock phase (≥1)
- CHAIN_DIR, {NUM_CHAINS{1'b0}}, bit c: 0 = chain c shifts pad k = P−1 first, descending; 1 = pad k = 0 first, ascending
- wb_clk_i  in  1  system clock; sole clock
- wb_rst_i  in  1  reset, asynchronous, active-high
- cfg_data  in  NUM_CHAINS*PADS_PER_CHAIN*CTRL_BITS  pad words; chain c, pad k word = cfg_data[((c*P+k)*CB) +: CB]; must be held stable while busy
- start  in  1  one-cycle request; honoured only in IDLE
- abort  in  1  terminates a running transfer with no latch
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on normal completion
- serial_clock  out  1  shift clock to the chains
- serial_resetn  out  1  active-low load strobe / chain reset
- serial_data_out  out  NUM_CHAINS  serial data, one bit per chain

## Operation
- Notation: P = PADS_PER_CHAIN, CB = CTRL_BITS, D = CLK_DIV.
- States: IDLE, LOAD, SHIFT, LATCH.
- IDLE:
  - serial_clock=0, serial_resetn=1, serial_data_out=0, busy=0.
  - start=1 → LOAD, and the pad counter resets to word 0.
- LOAD (1 cycle):
  - For each chain c, latch the staging register with the pad word selected by the pad counter and CHAIN_DIR[c].
  - serial_data_out[c] = staging MSB (bit CB−1) from the next cycle on.
  - Then → SHIFT with bit counter 0 and phase counter 0.
- SHIFT, per bit:
  - serial_clock low for D cycles, then high for D cycles.
  - On the high→low transition, every staging register shifts left, zero-filled. Data is MSB first and is stable across each rising edge.
  - After CB bits: if the pad counter = P−1 → LATCH; else increment the pad counter → LOAD.
- LATCH:
  - serial_clock=0; serial_resetn=0 for D cycles, then 1 for D cycles.
  - Then → IDLE with done=1 for exactly one cycle.
- abort=1 in LOAD, SHIFT or LATCH:
  - Next edge → IDLE: serial_clock=0, serial_resetn=1, serial_data_out=0.
  - No done pulse; the partial chain contents are not latched.
- Precedence and simultaneous events:
  - abort outranks start.
  - start while busy is ignored, not queued.
  - start in the done cycle is accepted, since the state is already IDLE.
- Counter widths are $clog2 of their range; pad-word index arithmetic is computed at full integer width before slicing.

## Timing
- Reset values (asynchronous, immediate): busy=0, done=0, serial_clock=0, serial_resetn=0 (chains held in reset), serial_data_out=0, state IDLE.
- First edge after wb_rst_i falls: serial_resetn→1.
- start sampled at edge 0: busy=1 from edge 1, which is the LOAD cycle.
- Per word: 1 + 2·D·CB cycles. Total busy T = P·(1 + 2·D·CB) + 2·D cycles.
- busy→0 and done=1 at edge 1+T; done falls at edge 2+T.
- Defaults: T = 19·27 + 2 = 515. With D=3: T = 19·79 + 6 = 1507.
- serial_clock low phase preceding the first bit of each word: D cycles, plus 1 LOAD cycle.
- wb_rst_i asserted mid-transfer: all outputs go to reset values within the same cycle, and no latch pulse is emitted beyond the reset-held serial_resetn=0.

## Test plan
- Defaults, distinct 13-bit word per pad (word = pad index·0x101 & 0x1FFF), start → 247 rising edges per chain:
  - chain 0 receives pads 18…0 and chain 1 receives pads 37…19, MSB first;
  - busy lasts 515 cycles, one done pulse, then serial_resetn low for 1 cycle.
- CLK_DIV=3, CHAIN_DIR=2'b10:
  - serial_clock high and low phases measure 3 cycles;
  - chain 1 order is pads 19…37;
  - T = 1507.
- start re-pulsed at cycles 10 and 200 of a transfer → ignored, single done. start in the done cycle → second transfer begins the next cycle with the same T.
- abort at cycle 100:
  - IDLE at the next edge, done never asserts;
  - serial_resetn never goes low;
  - serial_clock=0 and serial_data_out=0.
- wb_rst_i pulsed at cycle 300:
  - immediately serial_resetn=0, busy=0, serial_clock=0;
  - after release serial_resetn=1 and a fresh start completes normally.
- NUM_CHAINS=4, PADS_PER_CHAIN=5, CTRL_BITS=8, all-ones in chain 2 only → only serial_data_out[2] toggles high; T = 5·17 + 2 = 87.
